// File: rtl/mem_lane_sequencer_pkg.sv
// Shared types for the dual-lane memory request sequencer: FSM states,
// lane request bundle and access-type codes.
package mem_lane_sequencer_pkg;

    localparam int LANE_ADDR_W = 32;
    localparam int LANE_DATA_W = 32;
    localparam int LANE_TYPE_W = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic                   read_ena;
        logic                   write_ena;
        logic [LANE_TYPE_W-1:0] mem_type;
        logic [LANE_ADDR_W-1:0] addr;
        logic [LANE_DATA_W-1:0] write_data;
    } lane_req_t;

    localparam logic [LANE_TYPE_W-1:0] MT_BYTE   = 3'b000;
    localparam logic [LANE_TYPE_W-1:0] MT_HALF   = 3'b001;
    localparam logic [LANE_TYPE_W-1:0] MT_WORD   = 3'b010;
    localparam logic [LANE_TYPE_W-1:0] MT_BYTE_U = 3'b100;
    localparam logic [LANE_TYPE_W-1:0] MT_HALF_U = 3'b101;

endpackage

// File: rtl/mem_lane_sequencer.sv
// Serializes the two memory-stage lanes onto one request/response port in
// program order, captures load data per lane and stalls until both are done.
module mem_lane_sequencer
    import mem_lane_sequencer_pkg::*;
#(
    parameter int ADDR_W = LANE_ADDR_W,
    parameter int DATA_W = LANE_DATA_W,
    parameter int TYPE_W = LANE_TYPE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             lane_read_ena,
    input  logic [1:0]             lane_write_ena,
    input  logic [1:0][TYPE_W-1:0] lane_mem_type,
    input  logic [1:0][ADDR_W-1:0] lane_addr,
    input  logic [1:0][DATA_W-1:0] lane_write_data,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic                   req_we,
    output logic [TYPE_W-1:0]      req_type,
    output logic [ADDR_W-1:0]      req_addr,
    output logic [DATA_W-1:0]      req_wdata,
    input  logic                   resp_valid,
    input  logic [DATA_W-1:0]      resp_rdata,
    output logic [1:0][DATA_W-1:0] lane_read_data,
    output logic                   stall,
    output logic                   protocol_err
);

    seq_state_t             state_q, state_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
    logic                   perr_q, perr_d;
    logic [1:0]             access_s;
    logic [1:0]             is_load_s;
    logic                   lane_sel_s;

    // A lane with both enables set is a store, so only read-without-write loads.
    assign access_s  = lane_read_ena | lane_write_ena;
    assign is_load_s = lane_read_ena & ~lane_write_ena;

    // State, captured read data and sticky protocol error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    // Next-state, read-data capture and protocol error detection.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        perr_d  = perr_q;
        case (state_q)
            IDLE: begin
                if (access_s[0]) begin
                    state_d = REQ0;
                    rdata_d = '0;
                end else if (access_s[1]) begin
                    state_d = REQ1;
                    rdata_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ0: begin
                if (req_ready) begin
                    state_d = WAIT0;
                end else begin
                    state_d = REQ0;
                end
            end
            WAIT0: begin
                if (resp_valid) begin
                    if (is_load_s[0]) begin
                        rdata_d[0] = resp_rdata;
                    end else begin
                        rdata_d[0] = rdata_q[0];
                    end
                    state_d = access_s[1] ? REQ1 : DONE;
                end else begin
                    state_d = WAIT0;
                end
            end
            REQ1: begin
                if (req_ready) begin
                    state_d = WAIT1;
                end else begin
                    state_d = REQ1;
                end
            end
            WAIT1: begin
                if (resp_valid) begin
                    if (is_load_s[1]) begin
                        rdata_d[1] = resp_rdata;
                    end else begin
                        rdata_d[1] = rdata_q[1];
                    end
                    state_d = DONE;
                end else begin
                    state_d = WAIT1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Responses are only legal while waiting; one coincident with acceptance is dropped.
        if (resp_valid && (state_q != WAIT0) && (state_q != WAIT1)) begin
            perr_d = 1'b1;
        end else begin
            perr_d = perr_d;
        end
    end

    // Request port: lane fields while requesting, zero otherwise.
    always_comb begin
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_type   = '0;
        req_addr   = '0;
        req_wdata  = '0;
        lane_sel_s = (state_q == REQ1);
        if ((state_q == REQ0) || (state_q == REQ1)) begin
            req_valid = 1'b1;
            req_we    = lane_write_ena[lane_sel_s];
            req_type  = lane_mem_type[lane_sel_s];
            req_addr  = lane_addr[lane_sel_s];
            req_wdata = lane_write_ena[lane_sel_s] ? lane_write_data[lane_sel_s] : '0;
        end else begin
            req_valid = 1'b0;
        end
    end

    assign stall = ((state_q == IDLE) && (|access_s)) ||
                   ((state_q != IDLE) && (state_q != DONE));

    assign lane_read_data = rdata_q;
    assign protocol_err   = perr_q;

endmodule

// File: tb/tb_mem_lane_sequencer.sv
// Randomized self-checking bench: a bus-level memory responder plus a
// program-order reference for issue order, read results and stall length.
module tb_mem_lane_sequencer;
    import mem_lane_sequencer_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       lane_read_ena, lane_write_ena;
    logic [1:0][2:0]  lane_mem_type;
    logic [1:0][31:0] lane_addr, lane_write_data;
    logic             req_valid, req_ready, req_we;
    logic [2:0]       req_type;
    logic [31:0]      req_addr, req_wdata;
    logic             resp_valid;
    logic [31:0]      resp_rdata;
    logic [1:0][31:0] lane_read_data;
    logic             stall, protocol_err;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] mem [logic [31:0]];
    logic [1:0][31:0] prev_rd;

    mem_lane_sequencer dut (
        .clk(clk), .rst(rst),
        .lane_read_ena(lane_read_ena), .lane_write_ena(lane_write_ena),
        .lane_mem_type(lane_mem_type), .lane_addr(lane_addr),
        .lane_write_data(lane_write_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .lane_read_data(lane_read_data), .stall(stall),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] ad);
        if (!mem.exists(ad)) mem[ad] = $urandom;
        return mem[ad];
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        lane_read_ena = 2'b00; lane_write_ena = 2'b00;
        req_ready = 1'b0; resp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        prev_rd = '0;
    endtask

    // One bundle: rw = ready-wait cycles in REQ, dl = cycles spent in WAIT (>=1).
    task automatic run_bundle(input logic [1:0] re, input logic [1:0] we,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] wd0, input logic [31:0] wd1,
                              input logic [2:0] t0, input logic [2:0] t1,
                              input int rw0, input int rw1, input int dl0, input int dl1);
        logic [31:0] a [2];
        logic [31:0] wd [2];
        logic [2:0]  t [2];
        int          rw [2];
        int          dl [2];
        logic [31:0] exp_rd [2];
        int          lanes [$];
        int          exp_stall, stall_cnt, k, r_left, resp_left, l;
        bit          pending, finished;
        logic        cur_we;
        logic [31:0] cur_addr, cur_wd;
        a[0] = a0; a[1] = a1; wd[0] = wd0; wd[1] = wd1; t[0] = t0; t[1] = t1;
        rw[0] = rw0; rw[1] = rw1; dl[0] = dl0; dl[1] = dl1;
        exp_stall = 0;
        for (int i = 0; i < 2; i++) begin
            exp_rd[i] = 32'h0;
            if (re[i] || we[i]) begin
                lanes.push_back(i);
                exp_stall += rw[i] + 1 + dl[i];
                if (!we[i]) begin
                    if (i == 1 && we[0] && a0 == a1) exp_rd[i] = wd0;
                    else exp_rd[i] = mem_rd(a[i]);
                end
            end
        end
        if (lanes.size() > 0) exp_stall += 1;
        else begin
            exp_rd[0] = prev_rd[0];
            exp_rd[1] = prev_rd[1];
        end

        @(negedge clk);
        lane_read_ena = re; lane_write_ena = we;
        lane_addr[0] = a0; lane_addr[1] = a1;
        lane_write_data[0] = wd0; lane_write_data[1] = wd1;
        lane_mem_type[0] = t0; lane_mem_type[1] = t1;
        #1;
        k = 0; pending = 1'b0; stall_cnt = 0; finished = 1'b0; resp_left = 0;
        cur_we = 1'b0; cur_addr = 32'h0; cur_wd = 32'h0;
        r_left = (lanes.size() > 0) ? rw[lanes[0]] : 0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = $urandom;
            if (!stall) begin
                finished = 1'b1;
                check_val("done_req_valid", {63'h0, req_valid}, 64'h0);
                check_val("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
                check_val("req_count", 64'(k), 64'(lanes.size()));
                check_val("rd_lane0", {32'h0, lane_read_data[0]}, {32'h0, exp_rd[0]});
                check_val("rd_lane1", {32'h0, lane_read_data[1]}, {32'h0, exp_rd[1]});
                check_val("protocol_err", {63'h0, protocol_err}, 64'h0);
            end else begin
                stall_cnt++;
                if (req_valid) begin
                    if (k >= lanes.size()) begin
                        check_val("extra_req", {63'h0, req_valid}, 64'h0);
                        finished = 1'b1;
                    end else begin
                        l = lanes[k];
                        check_val("req_we", {63'h0, req_we}, {63'h0, we[l]});
                        check_val("req_addr", {32'h0, req_addr}, {32'h0, a[l]});
                        check_val("req_type", {61'h0, req_type}, {61'h0, t[l]});
                        if (we[l]) check_val("req_wdata", {32'h0, req_wdata}, {32'h0, wd[l]});
                        if (r_left == 0) begin
                            req_ready = 1'b1;
                            cur_we = req_we; cur_addr = req_addr; cur_wd = req_wdata;
                            pending = 1'b1;
                            resp_left = dl[l];
                            k++;
                            r_left = (k < lanes.size()) ? rw[lanes[k]] : 0;
                        end else begin
                            r_left--;
                        end
                    end
                end else begin
                    check_val("req_idle_zero", {req_we, req_type, req_addr, req_wdata}, 68'h0 >> 4);
                    if (pending) begin
                        if (resp_left == 1) begin
                            resp_valid = 1'b1;
                            pending = 1'b0;
                            if (cur_we) mem[cur_addr] = cur_wd;
                            else resp_rdata = mem_rd(cur_addr);
                        end else begin
                            resp_left--;
                        end
                    end
                end
            end
            if (!finished) begin
                @(negedge clk);
                #1;
            end
        end
        check_val("bundle_done", {63'h0, finished}, 64'h1);
        if (finished && stall == 1'b0) begin
            prev_rd[0] = exp_rd[0];
            prev_rd[1] = exp_rd[1];
        end else begin
            pulse_reset();
        end
    endtask

    initial begin
        rst = 1'b1;
        lane_read_ena = 2'b00; lane_write_ena = 2'b00;
        lane_mem_type = '0; lane_addr = '0; lane_write_data = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 32'h0;
        prev_rd = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_req_valid", {63'h0, req_valid}, 64'h0);
        check_val("rst_stall", {63'h0, stall}, 64'h0);
        check_val("rst_rdata", {lane_read_data}, 64'h0);
        check_val("rst_perr", {63'h0, protocol_err}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        mem[32'h100] = 32'hDEADBEEF;
        run_bundle(2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, MT_WORD, MT_WORD, 0, 0, 1, 1);
        run_bundle(2'b10, 2'b01, 32'h200, 32'h200, 32'h11223344, 32'h0, MT_WORD, MT_WORD, 0, 0, 1, 1);
        run_bundle(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, MT_BYTE, MT_BYTE, 0, 0, 1, 1);
        run_bundle(2'b11, 2'b00, 32'h204, 32'h208, 32'h0, 32'h0, MT_HALF, MT_BYTE_U, 4, 0, 1, 2);
        mem[32'h300] = 32'hA; mem[32'h304] = 32'hB;
        mem[32'h308] = 32'hC; mem[32'h30C] = 32'hD;
        run_bundle(2'b11, 2'b00, 32'h300, 32'h304, 32'h0, 32'h0, MT_WORD, MT_WORD, 0, 0, 1, 1);
        run_bundle(2'b11, 2'b00, 32'h308, 32'h30C, 32'h0, 32'h0, MT_WORD, MT_WORD, 0, 0, 1, 1);

        for (int n = 0; n < 40; n++) begin
            run_bundle(2'($urandom), 2'($urandom),
                       32'h200 + 32'($urandom_range(0, 3)) * 32'd4,
                       32'h200 + 32'($urandom_range(0, 3)) * 32'd4,
                       $urandom, $urandom, 3'($urandom), 3'($urandom),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
        end

        // Reset while waiting on lane 1, then a stray response afterwards.
        @(negedge clk);
        lane_read_ena = 2'b11; lane_write_ena = 2'b00;
        lane_addr[0] = 32'h300; lane_addr[1] = 32'h304;
        req_ready = 1'b1; resp_valid = 1'b0;
        @(negedge clk);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h55;
        @(negedge clk);
        resp_valid = 1'b0; req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        #1;
        check_val("wait1_stall", {63'h0, stall}, 64'h1);
        check_val("wait1_req_valid", {63'h0, req_valid}, 64'h0);
        check_val("wait1_rd0", {32'h0, lane_read_data[0]}, 64'h55);
        rst = 1'b1;
        lane_read_ena = 2'b00;
        #1;
        check_val("midrst_req_valid", {63'h0, req_valid}, 64'h0);
        check_val("midrst_stall", {63'h0, stall}, 64'h0);
        check_val("midrst_rdata", {lane_read_data}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        resp_valid = 1'b1;
        @(negedge clk);
        resp_valid = 1'b0;
        #1;
        check_val("late_resp_perr", {63'h0, protocol_err}, 64'h1);
        check_val("late_resp_stall", {63'h0, stall}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_lane_sequencer.md
Name: mem_lane_sequencer

Overview:
- Shares one single-port data-memory/dcache request channel between the two memory-stage issue lanes of the dual-issue pipeline.
- Serializes lane 0 then lane 1 in program order, captures read data per lane and raises a pipeline stall until both lanes' accesses are complete.
- Sits between the memory stage and the dcache/bus request port.
- Program-order serialization resolves lane0-write / lane1-read same-address hazards without forwarding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TYPE_W, 3, memory access type code width (byte/half/word, signed/unsigned; passed through, not decoded).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- lane_read_ena  in  2  per-lane load request; bit i = lane i.
- lane_write_ena  in  2  per-lane store request.
- lane_mem_type  in  2xTYPE_W  per-lane access type.
- lane_addr  in  2xADDR_W  per-lane address.
- lane_write_data  in  2xDATA_W  per-lane store data.
- req_valid  out  1  request to memory port.
- req_ready  in  1  memory port accepts request.
- req_we  out  1  1 = store, 0 = load.
- req_type  out  TYPE_W  access type of the current request.
- req_addr  out  ADDR_W  address of the current request.
- req_wdata  out  DATA_W  store data.
- resp_valid  in  1  response or ack; arrives at least 1 cycle after acceptance; stores also ack.
- resp_rdata  in  DATA_W  load data, valid with resp_valid.
- lane_read_data  out  2xDATA_W  captured load data per lane.
- stall  out  1  hold the memory stage.
- protocol_err  out  1  sticky: resp_valid seen outside WAIT0/WAIT1.

Behaviour:
- Reset (asynchronous): state IDLE, req_valid 0, lane_read_data 0, protocol_err 0, stall 0.
- access[i] = lane_read_ena[i] | lane_write_ena[i]. If both enables are set on one lane, treat it as a store.
- Lane inputs are stable while stall=1. The pipeline advances on the first cycle stall=0.
- Transitions:
  - IDLE: access[0] -> REQ0; else access[1] -> REQ1; else stay.
  - REQ0: req_valid=1 with lane 0 fields; req_ready -> WAIT0.
  - WAIT0: on resp_valid, capture resp_rdata into lane_read_data[0] if lane 0 is a load; then access[1] -> REQ1, else -> DONE.
  - REQ1 and WAIT1: same as REQ0/WAIT0 with lane 1 fields; WAIT1 on resp_valid -> DONE.
  - DONE: lasts exactly 1 cycle, then -> IDLE.
- req_valid is 1 only in REQ0/REQ1. Once asserted it stays high with constant fields until req_ready. Outside REQ states the req_* fields drive 0.
- stall (combinational) = (IDLE & (access[0] | access[1])) | state not in {IDLE, DONE}. In DONE stall=0 and lane_read_data holds both results.
  - A bundle with no access passes in 0 cycles with stall=0.
  - A new bundle is sampled only in IDLE, so a completed bundle is never re-issued.
- lane_read_data[i]:
  - Updated only on the capturing response.
  - Held otherwise; store lanes leave the value unchanged.
  - Cleared to 0 when IDLE accepts a new bundle with access.
- Minimum latency with req_ready=1 and response 1 cycle after accept:
  - Two accesses: IDLE->REQ0->WAIT0->REQ1->WAIT1->DONE, stall high for 5 cycles.
  - One access: stall high for 3 cycles.
- resp_valid in the same cycle as acceptance is a protocol violation. It is ignored and sets protocol_err.
- Reset mid-transaction: immediate return to IDLE with req_valid=0. A response arriving after reset, while in IDLE, sets protocol_err.
- Not supported: flush, and responses without a prior request.

Decomposition:
- Shared package holds:
  - seq_state_t enum: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
  - Lane request struct (read_ena, write_ena, mem_type, addr, write_data).
  - Memory-type code constants.
- No sub-module is required. The per-lane request mux (lane index -> req_* fields) may be a small function in the package.

Test Plan:
- Lane0 load 0x100, lane1 idle, req_ready=1, resp 1 cycle later with 0xDEADBEEF -> stall high 3 cycles; lane_read_data[0]=0xDEADBEEF in DONE; exactly one request issued.
- Lane0 store 0x200 data 0x11223344, lane1 load 0x200 -> store issued first (req_we=1) and load second; memory model returns 0x11223344 to lane 1; stall high 5 cycles.
- Both lanes idle -> stall=0, req_valid never asserted, state stays IDLE.
- req_ready held low 4 cycles in REQ0 -> req_valid and fields constant; stall stays 1; completion proceeds after ready.
- Assert rst while in WAIT1 -> next cycle state IDLE, req_valid=0, stall=0, lane_read_data=0; late resp_valid sets protocol_err=1.
- Two back-to-back bundles of dual loads (0xA / 0xB, then 0xC / 0xD) -> each bundle is issued exactly once and DONE presents the correct pair each time.
